// File: rtl/led_mmio_pkg.sv
// Shared constants for the LED MMIO peripheral:
// register offsets and STATUS bit positions.
package led_mmio_pkg;

   localparam logic [4:0] LED_DATA_OFF   = 5'h00;
   localparam logic [4:0] BLINK_MASK_OFF = 5'h04;
   localparam logic [4:0] BLINK_DIV_OFF  = 5'h08;
   localparam logic [4:0] STATUS_OFF     = 5'h0C;
   localparam logic [4:0] LED_SET_OFF    = 5'h10;
   localparam logic [4:0] LED_CLR_OFF    = 5'h14;

   localparam int STAT_PHASE_BIT = 0;
   localparam int STAT_RUN_BIT   = 1;

endpackage

// File: rtl/led_mmio_blink_timer.sv
// Blink half-period timer: counts 0..div-1, toggling phase on wrap.
// phase_next exposes the value phase takes at the coming edge.
module blink_timer #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic             restart,
   output logic             phase,
   output logic             phase_next
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // A restart beats a coincident wrap.
   always_comb begin
      cnt_d   = cnt_q + DIV_W'(1);
      phase_d = phase_q;
      if (restart || div == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == div - DIV_W'(1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   assign phase      = phase_q;
   assign phase_next = phase_d;

endmodule

// File: rtl/led_mmio.sv
// Memory-mapped LED peripheral: data/set/clear registers, blink mask
// and timer, one-deep response register on a valid/ready bus.
module led_mmio
   import led_mmio_pkg::*;
#(
   parameter int LED_W = 8,
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [4:0]       req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic [LED_W-1:0] led
);

   logic [LED_W-1:0] data_q, data_d;
   logic [LED_W-1:0] mask_q, mask_d;
   logic [LED_W-1:0] led_q, led_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             accept, restart;
   logic             phase, phase_next;
   logic [4:0]       off;
   logic             unused_bits;

   assign req_ready   = !rsp_valid_q | rsp_ready;
   assign accept      = req_valid & req_ready;
   assign off         = {req_addr[4:2], 2'b00};
   assign unused_bits = ^{req_addr[1:0], req_wdata[31:DIV_W]};

   blink_timer #(.DIV_W(DIV_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .div        (div_q),
      .restart    (restart),
      .phase      (phase),
      .phase_next (phase_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q      <= '0;
         mask_q      <= '0;
         div_q       <= '0;
         led_q       <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         data_q      <= data_d;
         mask_q      <= mask_d;
         div_q       <= div_d;
         led_q       <= led_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      data_d      = data_q;
      mask_d      = mask_q;
      div_d       = div_q;
      restart     = 1'b0;
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rdata_d     = rdata_q;
      err_d       = err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rdata_d     = '0;
         err_d       = 1'b0;
         if (req_we) begin
            unique case (off)
               LED_DATA_OFF:   data_d = req_wdata[LED_W-1:0];
               BLINK_MASK_OFF: mask_d = req_wdata[LED_W-1:0];
               BLINK_DIV_OFF: begin
                  div_d   = req_wdata[DIV_W-1:0];
                  restart = 1'b1;
               end
               LED_SET_OFF:    data_d = data_q | req_wdata[LED_W-1:0];
               LED_CLR_OFF:    data_d = data_q & ~req_wdata[LED_W-1:0];
               default:        err_d  = 1'b1;
            endcase
         end else begin
            unique case (off)
               LED_DATA_OFF:   rdata_d = 32'(data_q);
               BLINK_MASK_OFF: rdata_d = 32'(mask_q);
               BLINK_DIV_OFF:  rdata_d = 32'(div_q);
               STATUS_OFF: begin
                  rdata_d[STAT_PHASE_BIT] = phase;
                  rdata_d[STAT_RUN_BIT]   = |div_q;
               end
               default:        err_d = 1'b1;
            endcase
         end
      end
      led_d = data_d ^ (mask_d & {LED_W{phase_next}});
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign led       = led_q;

endmodule

// File: tb/tb_led_mmio.sv
// Scoreboard bench for led_mmio: a behavioural model predicts each
// response and the LED pins; a monitor compares at the falling edge.
module tb_led_mmio;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [4:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  led;

   int tests = 0;
   int fails = 0;

   led_mmio dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .led       (led)
   );

   always #5 clk = ~clk;

   // Model state: t counts edges since the last timer restart.
   logic [7:0]  m_data, m_mask;
   logic [23:0] m_div;
   int          t;
   bit          m_pend;
   logic [32:0] exp_q[$];
   bit          m_acc, m_restart, m_ph, e_err;
   logic [31:0] e_rdata;

   function automatic bit phase_at(int tt, logic [23:0] n);
      if (n == 0) return 1'b0;
      return ((tt / int'(n)) % 2) == 1;
   endfunction

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data = 0; m_mask = 0; m_div = 0; t = 0; m_pend = 0;
         exp_q.delete();
      end else begin
         m_acc     = req_valid && (!m_pend || rsp_ready);
         m_ph      = phase_at(t, m_div);
         m_restart = 0;
         if (m_acc) begin
            e_rdata = 0;
            e_err   = 0;
            if (req_we) begin
               case (req_addr >> 2)
                  0: m_data = req_wdata[7:0];
                  1: m_mask = req_wdata[7:0];
                  2: begin m_div = req_wdata[23:0]; m_restart = 1; end
                  4: m_data = m_data | req_wdata[7:0];
                  5: m_data = m_data & ~req_wdata[7:0];
                  default: e_err = 1;
               endcase
            end else begin
               case (req_addr >> 2)
                  0: e_rdata = {24'b0, m_data};
                  1: e_rdata = {24'b0, m_mask};
                  2: e_rdata = {8'b0, m_div};
                  3: e_rdata = {30'b0, m_div != 0, m_ph};
                  default: e_err = 1;
               endcase
            end
            exp_q.push_back({e_err, e_rdata});
         end
         m_pend = m_acc ? 1'b1 : (m_pend && !rsp_ready);
         t = m_restart ? 0 : t + 1;
      end
   end

   // Monitor: pins, handshake and queued responses.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_led", 32'(led), 0);
         check("rst_rsp_valid", 32'(rsp_valid), 0);
         check("rst_rdata", rsp_rdata, 0);
         check("rst_err", 32'(rsp_err), 0);
      end else begin
         check("led", 32'(led),
               32'(m_data ^ (m_mask & {8{phase_at(t, m_div)}})));
         check("req_ready", 32'(req_ready), 32'(!m_pend || rsp_ready));
         check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
         if (rsp_valid && exp_q.size() > 0) begin
            check("rdata", rsp_rdata, exp_q[0][31:0]);
            check("err", 32'(rsp_err), 32'(exp_q[0][32]));
            if (rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic req(input bit we, input logic [4:0] a,
                      input logic [31:0] d);
      bit r;
      int n = 0;
      req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
      forever begin
         @(negedge clk);
         r = req_ready;
         @(posedge clk);
         #2;
         if (r) break;
         n++;
         if (n > 50) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got no accept expected accept");
            break;
         end
      end
      req_valid = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      idle(3);
      rst = 0;
      idle(1);
      req(1, 5'h00, 32'hA5);
      req(0, 5'h00, 0);
      req(1, 5'h10, 32'h0F);
      req(1, 5'h14, 32'hA0);
      req(1, 5'h00, 0);
      req(1, 5'h04, 32'h03);
      req(1, 5'h08, 4);
      idle(5);
      req(0, 5'h0C, 0);
      idle(3);
      req(0, 5'h0C, 0);
      idle(10);
      req(1, 5'h08, 0);
      idle(3);
      // stall: response held while consumer not ready
      req(0, 5'h04, 0);
      rsp_ready = 0;
      fork
         begin idle(5); rsp_ready = 1; end
      join_none
      req(0, 5'h00, 0);
      idle(2);
      req(1, 5'h18, 32'hFF);
      req(0, 5'h10, 0);
      req(1, 5'h0C, 32'hFF);
      req(0, 5'h1F, 0);
      // reset while blinking with a response pending
      req(1, 5'h00, 32'h5A);
      req(1, 5'h08, 2);
      idle(3);
      rsp_ready = 0;
      req(0, 5'h00, 0);
      idle(1);
      rst = 1;
      idle(1);
      rst = 0;
      rsp_ready = 1;
      req(0, 5'h0C, 0);
      idle(2);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = $urandom_range(0, 1) == 1;
         req_addr  = 5'($urandom_range(0, 31));
         req_wdata = $urandom;
         if (req_addr[4:2] == 3'd2) req_wdata = $urandom_range(0, 6);
         rsp_ready = ($urandom_range(0, 3) != 0);
         idle(1);
      end
      req_valid = 0;
      rsp_ready = 1;
      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
